// File: rtl/pong_pkg.sv
// pong_pkg: screen/object geometry, RGB565 colours and helpers shared by the Pong blocks
package pong_pkg;
    localparam logic [9:0] SCREEN_W   = 10'd480;
    localparam logic [9:0] SCREEN_H   = 10'd272;
    localparam logic [9:0] BALL_SIZE  = 10'd10;
    localparam logic [9:0] PADDLE_W   = 10'd10;
    localparam logic [9:0] PADDLE_H   = 10'd60;
    localparam logic [9:0] PADDLE_L_X = 10'd20;
    localparam logic [9:0] PADDLE_R_X = 10'd450;
    localparam logic [9:0] DIG_W      = 10'd16;
    localparam logic [9:0] DIG_H      = 10'd24;
    localparam logic [9:0] SEG_T      = 10'd3;
    localparam logic [9:0] SEG_MID    = (DIG_H - SEG_T) / 10'd2;
    localparam logic [9:0] DIG_PITCH  = 10'd24;
    localparam logic [9:0] SCORE_Y    = 10'd8;
    localparam logic [9:0] SCORE_LX   = 10'd180;
    localparam logic [9:0] SCORE_RX   = 10'd264;
    localparam logic [9:0] NET_X      = 10'd238;
    localparam logic [9:0] NET_W      = 10'd4;
    localparam logic [9:0] RST_BALL_X   = 10'd240;
    localparam logic [9:0] RST_BALL_Y   = 10'd136;
    localparam logic [9:0] RST_PADDLE_Y = 10'd106;
    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_GREY   = 16'h8410;

    typedef enum logic [1:0] {BCD_IDLE, BCD_CONV, BCD_DONE} bcd_state_t;

    // Half-open span test done in 11 bits so lo + w can never wrap.
    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] w);
        return {1'b0, v} >= {1'b0, lo} && {1'b0, v} < {1'b0, lo} + {1'b0, w};
    endfunction

    function automatic logic [6:0] clamp99(input logic [6:0] s);
        return s > 7'd99 ? 7'd99 : s;
    endfunction
endpackage

// File: rtl/pong_renderer_if.sv
// pong_renderer_if: game state, raster timing in and RGB565 pixel/timing out of the renderer
//   master: game logic + timing generator side (drives state/raster, receives pixel)
//   slave : renderer side
interface pong_renderer_if;
    logic        frame_start;
    logic [9:0]  pix_x, pix_y;
    logic        de_in, hs_in, vs_in;
    logic        game_active;
    logic [9:0]  ball_x, ball_y;
    logic [9:0]  paddle_left_y, paddle_right_y;
    logic [6:0]  score_left, score_right;
    logic [15:0] rgb;
    logic        de_out, hs_out, vs_out;

    modport master (
        output frame_start, pix_x, pix_y, de_in, hs_in, vs_in, game_active,
               ball_x, ball_y, paddle_left_y, paddle_right_y, score_left, score_right,
        input  rgb, de_out, hs_out, vs_out
    );
    modport slave (
        input  frame_start, pix_x, pix_y, de_in, hs_in, vs_in, game_active,
               ball_x, ball_y, paddle_left_y, paddle_right_y, score_left, score_right,
        output rgb, de_out, hs_out, vs_out
    );
endinterface

// File: rtl/pong_seg7_glyph.sv
// pong_seg7_glyph: 7-segment glyph hit test inside one DIG_W x DIG_H digit box
//   digit : value 0..9 (others draw nothing)
//   en    : pixel lies inside the box and the digit is visible
//   lx/ly : pixel coordinate relative to the box top-left
//   hit   : pixel lies on a lit segment
module pong_seg7_glyph
    import pong_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       en,
    input  logic [9:0] lx,
    input  logic [9:0] ly,
    output logic       hit
);
    logic [6:0] seg;
    logic       upper, left, right;

    // seg bit order {a, b, c, d, e, f, g}
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

    assign upper = ly < DIG_H / 10'd2;
    assign left  = lx < SEG_T;
    assign right = lx >= DIG_W - SEG_T;

    assign hit = en && ((seg[6] && ly < SEG_T) ||
                        (seg[5] && right && upper) ||
                        (seg[4] && right && !upper) ||
                        (seg[3] && ly >= DIG_H - SEG_T) ||
                        (seg[2] && left && !upper) ||
                        (seg[1] && left && upper) ||
                        (seg[0] && ly >= SEG_MID && ly < SEG_MID + SEG_T));
endmodule

// File: rtl/pong_renderer.sv
// pong_renderer: per-frame snapshot of Pong state, BCD score conversion and 2-stage RGB565 pixel pipeline
//   clk_pix : pixel clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of pong_renderer_if (game state + raster in, rgb + aligned timing out)
module pong_renderer
    import pong_pkg::*;
(
    input  logic           clk_pix,
    input  logic           rst_n,
    pong_renderer_if.slave bus
);
    localparam logic [3:0][9:0] BOX_X = {SCORE_RX + DIG_PITCH, SCORE_RX, SCORE_LX + DIG_PITCH, SCORE_LX};

    logic [9:0]       snap_bx, snap_by, snap_pl, snap_pr;
    logic             snap_act;
    bcd_state_t       state;
    logic [6:0]       rem_l, rem_r;
    logic [3:0]       tens_l, tens_r;
    logic [3:0][3:0]  digits;
    logic [3:0]       seg_hit;
    logic             ball_hit, pad_hit, net_hit;
    logic             de1, hs1, vs1, ball1, pad1, seg1, net1;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            snap_bx  <= RST_BALL_X;
            snap_by  <= RST_BALL_Y;
            snap_pl  <= RST_PADDLE_Y;
            snap_pr  <= RST_PADDLE_Y;
            snap_act <= 1'b0;
        end else if (bus.frame_start) begin
            snap_bx  <= bus.ball_x;
            snap_by  <= bus.ball_y;
            snap_pl  <= bus.paddle_left_y;
            snap_pr  <= bus.paddle_right_y;
            snap_act <= bus.game_active;
        end
    end

    // The rem registers double as the clamped score snapshot; digits are published only in DONE.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BCD_IDLE;
            rem_l  <= 7'd0;
            rem_r  <= 7'd0;
            tens_l <= 4'd0;
            tens_r <= 4'd0;
            digits <= '0;
        end else if (bus.frame_start) begin
            state  <= BCD_CONV;
            rem_l  <= clamp99(bus.score_left);
            rem_r  <= clamp99(bus.score_right);
            tens_l <= 4'd0;
            tens_r <= 4'd0;
        end else begin
            case (state)
                BCD_CONV: begin
                    if (rem_l < 7'd10 && rem_r < 7'd10) begin
                        state <= BCD_DONE;
                    end else begin
                        if (rem_l >= 7'd10) begin
                            rem_l  <= rem_l - 7'd10;
                            tens_l <= tens_l + 4'd1;
                        end
                        if (rem_r >= 7'd10) begin
                            rem_r  <= rem_r - 7'd10;
                            tens_r <= tens_r + 4'd1;
                        end
                    end
                end
                BCD_DONE: begin
                    digits <= {rem_r[3:0], tens_r, rem_l[3:0], tens_l};
                    state  <= BCD_IDLE;
                end
                default: state <= BCD_IDLE;
            endcase
        end
    end

    // Digit boxes: 0 left tens, 1 left units, 2 right tens, 3 right units. Tens hidden when zero.
    for (genvar g = 0; g < 4; g++) begin : g_dig
        logic [9:0] lx, ly;
        logic       in_box;
        assign lx     = bus.pix_x - BOX_X[g];
        assign ly     = bus.pix_y - SCORE_Y;
        assign in_box = in_span(bus.pix_x, BOX_X[g], DIG_W) && in_span(bus.pix_y, SCORE_Y, DIG_H);
        pong_seg7_glyph u_glyph (
            .digit (digits[g]),
            .en    (in_box && ((g % 2) == 1 || digits[g] != 4'd0)),
            .lx    (lx),
            .ly    (ly),
            .hit   (seg_hit[g])
        );
    end

    assign ball_hit = snap_act && in_span(bus.pix_x, snap_bx, BALL_SIZE) && in_span(bus.pix_y, snap_by, BALL_SIZE);
    assign pad_hit  = (in_span(bus.pix_x, PADDLE_L_X, PADDLE_W) && in_span(bus.pix_y, snap_pl, PADDLE_H)) ||
                      (in_span(bus.pix_x, PADDLE_R_X, PADDLE_W) && in_span(bus.pix_y, snap_pr, PADDLE_H));
    // Dashed net: 8-line segments, drawn on even groups.
    assign net_hit  = in_span(bus.pix_x, NET_X, NET_W) && !bus.pix_y[3];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            {de1, ball1, pad1, seg1, net1} <= '0;
            {hs1, vs1}                     <= 2'b11;
            bus.rgb                        <= RGB_BLACK;
            bus.de_out                     <= 1'b0;
            bus.hs_out                     <= 1'b1;
            bus.vs_out                     <= 1'b1;
        end else begin
            de1        <= bus.de_in;
            hs1        <= bus.hs_in;
            vs1        <= bus.vs_in;
            ball1      <= ball_hit;
            pad1       <= pad_hit;
            seg1       <= |seg_hit;
            net1       <= net_hit;
            bus.rgb    <= !de1 ? RGB_BLACK :
                          (ball1 || pad1) ? RGB_WHITE :
                          seg1 ? RGB_YELLOW :
                          net1 ? RGB_GREY : RGB_BLACK;
            bus.de_out <= de1;
            bus.hs_out <= hs1;
            bus.vs_out <= vs1;
        end
    end
endmodule

// File: tb/tb_pong_renderer.sv
// tb_pong_renderer: scoreboard bench for pong_renderer; expected pixels queued at drive time, checked 2 clk later
module tb_pong_renderer;
    logic clk_pix = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    pong_renderer_if bus ();
    pong_renderer dut (.clk_pix(clk_pix), .rst_n(rst_n), .bus(bus));

    always #5 clk_pix = ~clk_pix;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] rgb;
        logic        de, hs, vs;
        int          x, y;
    } exp_t;
    exp_t q[$];

    int m_bx, m_by, m_pl, m_pr;
    bit m_act;
    int md[4];
    int box_x[4] = '{180, 204, 264, 288};

    function automatic bit seg_on(input int d, input int lx, input int ly);
        bit [6:0] m;
        case (d)
            0: m = 7'b1111110;  1: m = 7'b0110000;  2: m = 7'b1101101;
            3: m = 7'b1111001;  4: m = 7'b0110011;  5: m = 7'b1011011;
            6: m = 7'b1011111;  7: m = 7'b1110000;  8: m = 7'b1111111;
            9: m = 7'b1111011;  default: m = 7'b0;
        endcase
        return (m[6] && ly < 3) || (m[5] && lx >= 13 && ly < 12) || (m[4] && lx >= 13 && ly >= 12) ||
               (m[3] && ly >= 21) || (m[2] && lx < 3 && ly >= 12) || (m[1] && lx < 3 && ly < 12) ||
               (m[0] && ly >= 10 && ly < 13);
    endfunction

    function automatic logic [15:0] m_rgb(input int x, input int y, input bit de);
        if (!de) return 16'h0000;
        if (m_act && x >= m_bx && x < m_bx + 10 && y >= m_by && y < m_by + 10) return 16'hFFFF;
        if (x >= 20 && x < 30 && y >= m_pl && y < m_pl + 60) return 16'hFFFF;
        if (x >= 450 && x < 460 && y >= m_pr && y < m_pr + 60) return 16'hFFFF;
        for (int i = 0; i < 4; i++)
            if (x >= box_x[i] && x < box_x[i] + 16 && y >= 8 && y < 32 && (i % 2 == 1 || md[i] != 0) &&
                seg_on(md[i], x - box_x[i], y - 8))
                return 16'hFFE0;
        if (x >= 238 && x < 242 && ((y / 8) % 2) == 0) return 16'h8410;
        return 16'h0000;
    endfunction

    function automatic void model_reset();
        m_bx = 240; m_by = 136; m_pl = 106; m_pr = 106; m_act = 0;
        for (int i = 0; i < 4; i++) md[i] = 0;
    endfunction

    always @(negedge clk_pix) begin
        exp_t e;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc) begin
                fails++;
                $display("FAIL stale pixel(%0d,%0d): due cyc %0d, now cyc %0d", e.x, e.y, e.due, cyc);
            end else if ({bus.rgb, bus.de_out, bus.hs_out, bus.vs_out} !== {e.rgb, e.de, e.hs, e.vs}) begin
                fails++;
                $display("FAIL pixel(%0d,%0d) cyc %0d: got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                         e.x, e.y, cyc, bus.rgb, bus.de_out, bus.hs_out, bus.vs_out, e.rgb, e.de, e.hs, e.vs);
            end
        end
    end

    task automatic px(input int x, input int y, input bit de);
        exp_t e;
        bit hs, vs;
        hs = 1'($urandom);
        vs = 1'($urandom);
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        bus.de_in = de;
        bus.hs_in = hs;
        bus.vs_in = vs;
        e.due = cyc + 2; e.rgb = m_rgb(x, y, de); e.de = de; e.hs = hs; e.vs = vs; e.x = x; e.y = y;
        q.push_back(e);
        @(posedge clk_pix); #2;
    endtask

    task automatic expect_reset(input int due);
        exp_t e;
        e.due = due; e.rgb = 16'h0000; e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.x = -1; e.y = -1;
        q.push_back(e);
    endtask

    task automatic set_game(input int bx, input int by, input int pl, input int pr, input bit act,
                            input int sl, input int sr);
        bus.ball_x = 10'(bx); bus.ball_y = 10'(by);
        bus.paddle_left_y = 10'(pl); bus.paddle_right_y = 10'(pr);
        bus.game_active = act;
        bus.score_left = 7'(sl); bus.score_right = 7'(sr);
    endtask

    task automatic fs(input int idle);
        int sl, sr;
        bus.frame_start = 1'b1;
        m_bx = bus.ball_x; m_by = bus.ball_y; m_pl = bus.paddle_left_y; m_pr = bus.paddle_right_y;
        m_act = bus.game_active;
        sl = bus.score_left > 99 ? 99 : int'(bus.score_left);
        sr = bus.score_right > 99 ? 99 : int'(bus.score_right);
        md[0] = sl / 10; md[1] = sl % 10; md[2] = sr / 10; md[3] = sr % 10;
        px(0, 0, 0);
        bus.frame_start = 1'b0;
        repeat (idle) px(0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_x = '0; bus.pix_y = '0;
        bus.de_in = 1'b1; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
        set_game(0, 0, 0, 0, 1, 0, 0);
        model_reset();
        @(posedge clk_pix); #2;
        expect_reset(cyc);
        @(posedge clk_pix); #2;
        expect_reset(cyc);
        rst_n = 1'b1;
        px(0, 0, 0);
        px(0, 0, 0);
    endtask

    task automatic test_ball_paddles();
        set_game(240, 136, 106, 106, 1, 0, 0);
        fs(12);
        px(245, 140, 1);
        px(100, 100, 1);
        px(249, 145, 1);
        px(250, 140, 1);
        px(240, 146, 1);
        px(20, 106, 1);
        px(29, 165, 1);
        px(30, 110, 1);
        px(455, 110, 1);
        px(455, 166, 1);
    endtask

    task automatic test_scores();
        set_game(240, 136, 106, 106, 1, 57, 0);
        fs(12);
        px(185, 9, 1);
        px(209, 9, 1);
        px(209, 30, 1);
        px(185, 30, 1);
        px(185, 19, 1);
        px(269, 9, 1);
        px(293, 9, 1);
        px(293, 19, 1);
    endtask

    task automatic test_clamp();
        set_game(240, 136, 106, 106, 1, 120, 99);
        fs(12);
        px(185, 9, 1);
        px(181, 25, 1);
        px(209, 19, 1);
        px(269, 9, 1);
    endtask

    task automatic test_restart();
        set_game(240, 136, 106, 106, 1, 57, 3);
        fs(4);
        set_game(240, 136, 106, 106, 1, 12, 88);
        fs(12);
        px(185, 9, 1);
        px(194, 10, 1);
        px(209, 9, 1);
        px(270, 19, 1);
        px(293, 19, 1);
    endtask

    task automatic test_freeze();
        set_game(100, 100, 106, 106, 1, 12, 88);
        px(245, 140, 1);
        px(105, 105, 1);
        fs(2);
        px(105, 105, 1);
        px(245, 140, 1);
    endtask

    task automatic test_overlaps();
        set_game(236, 4, 106, 106, 1, 12, 88);
        fs(2);
        px(240, 8, 1);
        px(240, 8, 0);
        set_game(236, 4, 106, 106, 0, 12, 88);
        fs(2);
        px(240, 8, 1);
        px(240, 4, 1);
        px(239, 16, 1);
        px(242, 4, 1);
    endtask

    task automatic test_reset_mid();
        set_game(100, 50, 200, 150, 1, 12, 88);
        fs(12);
        px(105, 55, 1);
        px(25, 210, 1);
        set_game(100, 50, 200, 150, 1, 45, 45);
        bus.frame_start = 1'b1;
        @(posedge clk_pix); #2;
        bus.frame_start = 1'b0;
        @(posedge clk_pix); #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        bus.pix_x = 10'd105; bus.pix_y = 10'd55; bus.de_in = 1'b1; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
        expect_reset(cyc);
        @(posedge clk_pix); #2;
        expect_reset(cyc);
        @(posedge clk_pix); #2;
        rst_n = 1'b1;
        px(105, 55, 1);
        px(25, 210, 1);
        px(25, 110, 1);
        px(194, 10, 1);
        px(209, 9, 1);
        repeat (14) px(0, 0, 0);
        px(293, 9, 1);
        px(270, 19, 1);
    endtask

    initial begin
        test_reset();
        test_ball_paddles();
        test_scores();
        test_clamp();
        test_restart();
        test_freeze();
        test_overlaps();
        test_reset_mid();
        repeat (4) px(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
